// File: rtl/uart_tx_param_if.sv
// Host-side bus of the parametrised UART transmitter.
// Groups the write strobe, data, per-frame configuration and status flags.
// When UART_TX_BREAK_EN is defined the bus also carries send_break.
interface uart_tx_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 wr_en;
    logic [DATA_BITS-1:0] d_in;
    logic [1:0]           parity_mode;
    logic                 stop2;
`ifdef UART_TX_BREAK_EN
    logic                 send_break;
`endif
    logic                 tx_full;
    logic                 tx_empty;
    logic [CNT_W-1:0]     fifo_count;
    logic                 tx_busy;
    logic                 tx;

`ifdef UART_TX_BREAK_EN
    modport master (
        output wr_en, d_in, parity_mode, stop2, send_break,
        input  tx_full, tx_empty, fifo_count, tx_busy, tx
    );
    modport slave (
        input  wr_en, d_in, parity_mode, stop2, send_break,
        output tx_full, tx_empty, fifo_count, tx_busy, tx
    );
`else
    modport master (
        output wr_en, d_in, parity_mode, stop2,
        input  tx_full, tx_empty, fifo_count, tx_busy, tx
    );
    modport slave (
        input  wr_en, d_in, parity_mode, stop2,
        output tx_full, tx_empty, fifo_count, tx_busy, tx
    );
`endif
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an integrated TX FIFO.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2
// stop bits; parity and stop-bit count are latched per frame at pop time.
// Optional line-break generator enabled by defining UART_TX_BREAK_EN.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int BAUD_DIV   = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_param_if.slave bus
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_BREAK_EN
    localparam int BRK_LEN = (DATA_BITS + 4) * BAUD_DIV;
    localparam int BRK_W   = $clog2(BRK_LEN);
    localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(BRK_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`endif

    // Parity over the data word; odd=1 inverts the even-parity result.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
        return (^data) ^ odd;
    endfunction

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 full_r;
    logic                 empty_r;

    // Transmit FSM state
    state_t               state_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [BAUD_W-1:0]    baud_cnt_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic                 stop_cnt_r;
    logic                 par_en_r;
    logic                 par_bit_r;
    logic                 stop2_r;
    logic                 tx_r;
    logic                 busy_r;
`ifdef UART_TX_BREAK_EN
    logic [BRK_W-1:0]     brk_cnt_r;
    logic                 brk_mark_r;
`endif

    // Combinational control
    logic                 push_s;
    logic                 pop_s;
    logic                 brk_req_s;
    logic                 stop_done_s;
    logic [CNT_W-1:0]     count_next_s;
    logic [DATA_BITS-1:0] head_s;
    logic                 head_par_en_s;
    logic                 head_par_bit_s;

    // Push/pop decisions, next occupancy and the per-frame config of the head word.
    always_comb begin
        brk_req_s = 1'b0;
`ifdef UART_TX_BREAK_EN
        brk_req_s = bus.send_break;
`endif
        head_s         = mem[rd_ptr_r];
        head_par_en_s  = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
        head_par_bit_s = parity_bit(head_s, bus.parity_mode == 2'b10);

        push_s      = bus.wr_en && !full_r;
        stop_done_s = (state_r == ST_STOP) && (baud_cnt_r == '0) && (stop_cnt_r == 1'b0);

        case (state_r)
            ST_IDLE: begin
                pop_s = !brk_req_s && !empty_r;
            end
            ST_STOP: begin
                pop_s = stop_done_s && !empty_r;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase

        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO data array; contents need no reset because pointers gate every read.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            mem[wr_ptr_r] <= bus.d_in;
        end else begin
            mem[wr_ptr_r] <= mem[wr_ptr_r];
        end
    end

    // FIFO pointers and registered occupancy flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == '0);
        end
    end

    // Transmit FSM: tx and tx_busy are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            shift_r    <= '0;
            baud_cnt_r <= '0;
            bit_cnt_r  <= '0;
            stop_cnt_r <= 1'b0;
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            stop2_r    <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_cnt_r  <= '0;
            brk_mark_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (brk_req_s) begin
                        state_r    <= ST_BREAK;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        brk_cnt_r  <= BRK_LAST;
                        brk_mark_r <= 1'b0;
                    end else
`endif
                    if (pop_s) begin
                        state_r    <= ST_START;
                        shift_r    <= head_s;
                        par_en_r   <= head_par_en_s;
                        par_bit_r  <= head_par_bit_s;
                        stop2_r    <= bus.stop2;
                        baud_cnt_r <= BAUD_LAST;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_cnt_r == '0) begin
                        state_r    <= ST_DATA;
                        tx_r       <= shift_r[0];
                        bit_cnt_r  <= BIT_LAST;
                        baud_cnt_r <= BAUD_LAST;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_r == '0) begin
                        baud_cnt_r <= BAUD_LAST;
                        if (bit_cnt_r == '0) begin
                            if (par_en_r) begin
                                state_r <= ST_PARITY;
                                tx_r    <= par_bit_r;
                            end else begin
                                state_r    <= ST_STOP;
                                tx_r       <= 1'b1;
                                stop_cnt_r <= stop2_r;
                            end
                        end else begin
                            shift_r   <= shift_r >> 1;
                            tx_r      <= shift_r[1];
                            bit_cnt_r <= bit_cnt_r - BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (baud_cnt_r == '0) begin
                        state_r    <= ST_STOP;
                        tx_r       <= 1'b1;
                        stop_cnt_r <= stop2_r;
                        baud_cnt_r <= BAUD_LAST;
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_cnt_r == '0) begin
                        if (stop_cnt_r) begin
                            // second stop bit of a two-stop-bit frame
                            stop_cnt_r <= 1'b0;
                            baud_cnt_r <= BAUD_LAST;
                        end else if (pop_s) begin
                            // back-to-back frame, no idle cycle in between
                            state_r    <= ST_START;
                            shift_r    <= head_s;
                            par_en_r   <= head_par_en_s;
                            par_bit_r  <= head_par_bit_s;
                            stop2_r    <= bus.stop2;
                            baud_cnt_r <= BAUD_LAST;
                            tx_r       <= 1'b0;
                            busy_r     <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            tx_r    <= 1'b1;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r - BAUD_W'(1);
                    end
                end
`ifdef UART_TX_BREAK_EN
                ST_BREAK: begin
                    if (!brk_mark_r) begin
                        // low phase: minimum length, then extended while send_break stays high
                        if (brk_cnt_r != '0) begin
                            brk_cnt_r <= brk_cnt_r - BRK_W'(1);
                        end else if (!bus.send_break) begin
                            brk_mark_r <= 1'b1;
                            tx_r       <= 1'b1;
                            baud_cnt_r <= BAUD_LAST;
                        end else begin
                            tx_r <= 1'b0;
                        end
                    end else begin
                        // one bit period of mark before returning to idle
                        if (baud_cnt_r == '0) begin
                            state_r    <= ST_IDLE;
                            brk_mark_r <= 1'b0;
                            busy_r     <= 1'b0;
                        end else begin
                            baud_cnt_r <= baud_cnt_r - BAUD_W'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx         = tx_r;
    assign bus.tx_busy    = busy_r;
    assign bus.tx_full    = full_r;
    assign bus.tx_empty   = empty_r;
    assign bus.fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param (DATA_BITS=8, FIFO_DEPTH=16, BAUD_DIV=4).
// A reference model keeps the queued words in a queue and, whenever a word
// starts, expands the whole frame into a per-cycle list of expected tx levels.
module tb_uart_tx_param;
    localparam int DB = 8;
    localparam int FD = 16;
    localparam int BD = 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    uart_tx_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

    uart_tx_param #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .BAUD_DIV(BD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   mq[$];      // words waiting in the FIFO
    logic wave[$];    // remaining tx levels of the current frame / break
    bit   in_brk;
    bit   brk_low;

    function automatic logic m_tx();
        return (wave.size() > 0) ? wave[0] : 1'b1;
    endfunction

    task automatic build_frame(input logic [DB-1:0] w, input logic [1:0] pm, input logic s2);
        logic p;
        repeat (BD) wave.push_back(1'b0);
        for (int i = 0; i < DB; i++) repeat (BD) wave.push_back(w[i]);
        if (pm == 2'b01 || pm == 2'b10) begin
            p = 1'b0;
            for (int i = 0; i < DB; i++) p = p ^ w[i];
            if (pm == 2'b10) p = ~p;
            repeat (BD) wave.push_back(p);
        end
        repeat (BD * (s2 ? 2 : 1)) wave.push_back(1'b1);
    endtask

    task automatic model_edge();
        int  n;
        bit  idle;
        bit  ending;
        bit  brk_start;
        bit  do_pop;
        bit  sb;
        int  head;
        if (!reset) begin
            mq.delete();
            wave.delete();
            in_brk  = 1'b0;
            brk_low = 1'b0;
            return;
        end
        sb = 1'b0;
`ifdef UART_TX_BREAK_EN
        sb = bus.send_break;
`endif
        n         = mq.size();
        idle      = (wave.size() == 0);
        ending    = (wave.size() == 1) && !in_brk;
        brk_start = idle && sb;
        do_pop    = !brk_start && (idle || ending) && (n > 0);
        if (in_brk) begin
            if (brk_low && wave.size() == 1) begin
                if (!sb) begin
                    void'(wave.pop_front());
                    repeat (BD) wave.push_back(1'b1);
                    brk_low = 1'b0;
                end
            end else begin
                void'(wave.pop_front());
                if (wave.size() == 0) in_brk = 1'b0;
            end
        end else if (!idle) begin
            void'(wave.pop_front());
        end
        if (brk_start) begin
            repeat ((DB + 4) * BD) wave.push_back(1'b0);
            in_brk  = 1'b1;
            brk_low = 1'b1;
        end
        if (do_pop) begin
            head = mq.pop_front();
            build_frame(head[DB-1:0], bus.parity_mode, bus.stop2);
        end
        if (bus.wr_en && n < FD) mq.push_back(int'(bus.d_in));
    endtask

    // Advance the reference model on every active clock edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        model_edge();
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_val("tx",       32'(bus.tx),         32'(m_tx()));
        check_val("tx_busy",  32'(bus.tx_busy),    32'(wave.size() > 0));
        check_val("count",    32'(bus.fifo_count), 32'(mq.size()));
        check_val("tx_full",  32'(bus.tx_full),    32'(mq.size() == FD));
        check_val("tx_empty", 32'(bus.tx_empty),   32'(mq.size() == 0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_word(input logic [DB-1:0] d, input logic [1:0] pm, input logic s2);
        bus.wr_en       = 1'b1;
        bus.d_in        = d;
        bus.parity_mode = pm;
        bus.stop2       = s2;
        tick();
        bus.wr_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        cyc   = 0;
        n_cmp = 0;
        n_bad = 0;
        in_brk  = 1'b0;
        brk_low = 1'b0;
        reset           = 1'b0;
        bus.wr_en       = 1'b0;
        bus.d_in        = '0;
        bus.parity_mode = 2'b00;
        bus.stop2       = 1'b0;
`ifdef UART_TX_BREAK_EN
        bus.send_break  = 1'b0;
`endif
        run(3);
        check_val("rst_tx",    32'(bus.tx),         32'd1);
        check_val("rst_busy",  32'(bus.tx_busy),    32'd0);
        check_val("rst_empty", 32'(bus.tx_empty),   32'd1);
        check_val("rst_full",  32'(bus.tx_full),    32'd0);
        check_val("rst_count", 32'(bus.fifo_count), 32'd0);
        reset = 1'b1;
        run(2);

        // 1: single frame 0x55, no parity, one stop bit
        write_word(8'h55, 2'b00, 1'b0);
        check_val("t1_latency_hi", 32'(bus.tx), 32'd1);
        tick();
        check_val("t1_start", 32'(bus.tx), 32'd0);
        run(39);
        check_val("t1_last_stop", 32'(bus.tx), 32'd1);
        tick();
        check_val("t1_busy_fall", 32'(bus.tx_busy), 32'd0);
        check_val("t1_empty", 32'(bus.tx_empty), 32'd1);
        run(5);

        // 2: even then odd parity on 0xA7 (five ones)
        write_word(8'hA7, 2'b01, 1'b0);
        tick();
        run(37);
        check_val("t2_even_par", 32'(bus.tx), 32'd1);
        run(10);
        write_word(8'hA7, 2'b10, 1'b0);
        tick();
        run(37);
        check_val("t2_odd_par", 32'(bus.tx), 32'd0);
        run(10);

        // 3: overflow with 18 back-to-back writes
        for (int i = 0; i < 18; i++) begin
            write_word(8'(i), 2'b00, 1'b0);
            if (i == 16) begin
                check_val("t3_count16", 32'(bus.fifo_count), 32'd16);
                check_val("t3_full",    32'(bus.tx_full),    32'd1);
            end
        end
        check_val("t3_drop_count", 32'(bus.fifo_count), 32'd16);
        run(17 * 40 + 10);
        check_val("t3_drained", 32'(bus.tx_empty), 32'd1);

        // 4: two stop bits, stop2 dropped during the first frame's data
        write_word(8'h0F, 2'b00, 1'b1);
        write_word(8'hF0, 2'b00, 1'b1);
        run(10);
        bus.stop2 = 1'b0;
        run(110);

        // 5: reset pulse during data bit 3 with three words queued
        for (int i = 0; i < 4; i++) write_word(8'hC3 + 8'(i), 2'b00, 1'b0);
        run(15);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check_val("t5_tx",    32'(bus.tx),         32'd1);
        check_val("t5_count", 32'(bus.fifo_count), 32'd0);
        check_val("t5_busy",  32'(bus.tx_busy),    32'd0);
        run(100);

`ifdef UART_TX_BREAK_EN
        // 6: break held 10 cycles with one word queued
        bus.send_break = 1'b1;
        write_word(8'h3C, 2'b00, 1'b0);
        run(9);
        bus.send_break = 1'b0;
        run(38);
        check_val("t6_brk_low", 32'(bus.tx), 32'd0);
        tick();
        check_val("t6_brk_mark", 32'(bus.tx), 32'd1);
        run(60);
`endif

        // randomized traffic with occasional resets and config changes
        for (int i = 0; i < 4000; i++) begin
            bus.wr_en       = ($urandom_range(0, 5) == 0);
            bus.d_in        = 8'($urandom);
            bus.parity_mode = 2'($urandom_range(0, 3));
            bus.stop2       = 1'($urandom_range(0, 1));
            reset           = ($urandom_range(0, 1499) != 0);
`ifdef UART_TX_BREAK_EN
            bus.send_break  = ($urandom_range(0, 149) == 0);
`endif
            tick();
        end
        bus.wr_en = 1'b0;
        reset     = 1'b1;
`ifdef UART_TX_BREAK_EN
        bus.send_break = 1'b0;
`endif
        run(1000);
        check_val("final_idle", 32'(bus.tx_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
